qif_synapse: RTL and testbench
==============================

# qif_synapse

Spike-driven synaptic current generator: accepts weighted spike events over a valid/ready handshake and keeps a decaying fixed-point current accumulator. It presents the accumulator as a saturated signed 8-bit current `I_syn`. The block is the input side of the QIF neuron datapath: its `I_syn` output drives the neuron's `I_syn` input, and upstream spike sources, including neuron spike outputs, drive it.

## Interface
- `WIDTH`, 8: output current width, signed.
- `ACC_W`, 16: accumulator width, signed.
- `FRAC`, 4: fractional bits in accumulator.
- `DECAY_SHIFT`, 3: decay factor, acc -= acc>>>DECAY_SHIFT per tick.
- `PRESCALE`, 4: cycles between decay ticks (≥1).

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clr`  in  1  synchronous clear of accumulator and `sat_flag`.
- `spike_valid`  in  1  spike event offered.
- `spike_weight`  in  WIDTH  signed weight of offered spike.
- `spike_ready`  out  1  block can accept a spike this cycle.
- `I_syn`  out  WIDTH  signed synaptic current, registered.
- `active`  out  1  accumulator non-zero (state ACTIVE).
- `sat_flag`  out  1  sticky: a clip occurred since reset/`clr`.

## Operation
- Reset value of every register and output is 0; `acc` = 0; state = IDLE; prescaler = 0; `spike_ready` = 0.
- `spike_ready` is registered: 0 while `rst_n` low; 1 from the first rising edge after release. It stays 1 thereafter, except in a cycle with `clr` high.
- A spike is accepted on an edge where `spike_valid && spike_ready`. The weight is sign-extended and shifted left by FRAC bits, then added.
- Decay tick: occurs when state = ACTIVE and prescaler = PRESCALE-1. On a tick, d = acc>>>DECAY_SHIFT (arithmetic).
  - If d = 0 and acc ≠ 0, d = ±1 LSB toward zero, so acc always reaches 0.
- Next-accumulator rule, applied in the same cycle for simultaneous events: acc_next = sat_ACC_W(acc − d_tick + (w<<FRAC)_accepted).
- `I_syn` is computed as sat_WIDTH(acc_next>>>FRAC) and registered together with acc.
- Saturation clamps to [−2^(N−1), 2^(N−1)−1]. Any clip, at the accumulator or at the output, sets `sat_flag`.
- State machine:
  - IDLE → ACTIVE: when acc_next ≠ 0.
  - ACTIVE → IDLE: when acc_next = 0.
  - Prescaler increments only in ACTIVE. It wraps PRESCALE-1 → 0 and is forced to 0 on entering IDLE.
- `clr` has priority over spikes and decay. It sets acc = 0, `I_syn` = 0, state = IDLE, prescaler = 0 and `sat_flag` = 0. A spike offered in a `clr` cycle is not accepted, because `spike_ready` is 0.
- `active` = (state = ACTIVE), registered.

## Timing
- Accepted spike on edge N → `I_syn` and `active` updated at edge N; visible in cycle N+1. Latency is 1 cycle.
- First decay tick occurs PRESCALE cycles after the IDLE→ACTIVE edge. Subsequent ticks occur every PRESCALE cycles.
- Asserting `rst_n` low forces all outputs to 0 immediately, without a clock edge, and aborts any in-progress decay.
- Throughput: one spike per cycle.

## Structure
- Shared package `qif_pkg` holds:
  - state enum `syn_state_t` (IDLE, ACTIVE);
  - default constants `QIF_WIDTH`, `QIF_FRAC`;
  - the saturate function used by this block and the neuron.
- One sub-module: `qif_sat`, a parameterised signed saturator (in width, out width, clip flag). It is instantiated twice, at the accumulator and at the output.

## Test plan
Default parameters are used throughout.
- Reset:
  - Stimulus: hold `rst_n` low for 3 cycles, `spike_valid` = 1.
  - Required response: `I_syn` = 0, `active` = 0, `spike_ready` = 0 throughout; `spike_ready` = 1 one edge after release; no spike accepted during reset.
- Single spike:
  - Stimulus: w = 40.
  - Required response: next cycle `I_syn` = 40, `active` = 1. After 4 cycles acc = 640 − 80 = 560, so `I_syn` = 35.
- Saturation:
  - Stimulus: 3 consecutive spikes of w = 127.
  - Required response: `I_syn` = 127 from the 2nd spike on, `sat_flag` = 1.
  - Then `clr`: `I_syn` = 0, `sat_flag` = 0, `active` = 0.
  - Negative case: two spikes of w = −128 → `I_syn` = −128.
- Simultaneous tick and spike:
  - Stimulus: acc = 640 at a tick edge, spike w = 10 on the same edge.
  - Required response: acc = 720, `I_syn` = 45.
- Decay to idle:
  - Stimulus: single spike w = 1 (acc = 16).
  - Required response: acc sequence 16, 14, 13, 12, 11, 10, 9, 8, 7, …, 1, 0, one value per tick. `active` falls on the edge acc reaches 0, and the prescaler restarts at 0 on the next spike.
- Reset mid-operation:
  - Stimulus: `I_syn` = 35, drop `rst_n` between clock edges.
  - Required response: `I_syn` = 0 and `active` = 0 before the next edge; after release, the block resumes from IDLE.

Source files
------------

// File: rtl/qif_pkg.sv
// rtl/qif_pkg.sv - shared types, defaults and saturation helper for the QIF datapath
package qif_pkg;

    localparam int QIF_WIDTH = 8;
    localparam int QIF_FRAC  = 4;

    typedef enum logic [0:0] {
        SYN_IDLE   = 1'b0,
        SYN_ACTIVE = 1'b1
    } syn_state_t;

    // Clamp a sign-extended value into the signed range of a w-bit word (w <= 31).
    function automatic logic signed [31:0] qif_saturate(input logic signed [31:0] x,
                                                         input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

endpackage

// File: rtl/qif_sat.sv
// rtl/qif_sat.sv - parameterised signed saturator with clip indication
module qif_sat
    import qif_pkg::*;
#(
    parameter int IN_W  = 18,
    parameter int OUT_W = 16
) (
    input  logic signed [IN_W-1:0]  din,
    output logic signed [OUT_W-1:0] dout,
    output logic                    clip
);

    logic signed [31:0] ext;
    logic signed [31:0] sat;

    assign ext  = {{(32-IN_W){din[IN_W-1]}}, din};
    assign sat  = qif_saturate(ext, OUT_W);
    assign dout = sat[OUT_W-1:0];
    assign clip = (sat != ext);

endmodule

// File: rtl/qif_synapse.sv
// rtl/qif_synapse.sv - spike-driven decaying synaptic current generator
module qif_synapse
    import qif_pkg::*;
#(
    parameter int WIDTH       = QIF_WIDTH,
    parameter int ACC_W       = 16,
    parameter int FRAC        = QIF_FRAC,
    parameter int DECAY_SHIFT = 3,
    parameter int PRESCALE    = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clr,
    input  logic                    spike_valid,
    input  logic signed [WIDTH-1:0] spike_weight,
    output logic                    spike_ready,
    output logic signed [WIDTH-1:0] I_syn,
    output logic                    active,
    output logic                    sat_flag
);

    // Two guard bits cover acc - d + weight before the accumulator clamp.
    localparam int SUM_W = ACC_W + 2;
    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    syn_state_t              state;
    logic [PS_W-1:0]         ps;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_shift;
    logic signed [ACC_W-1:0] dec;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W-1:0] acc_scaled;
    logic signed [SUM_W-1:0] acc_ext;
    logic signed [SUM_W-1:0] dec_ext;
    logic signed [SUM_W-1:0] w_ext;
    logic signed [SUM_W-1:0] sum;
    logic signed [WIDTH-1:0] i_next;
    logic                    ready_q;
    logic                    accept;
    logic                    tick;
    logic                    clip_acc;
    logic                    clip_out;

    assign spike_ready = ready_q & ~clr;
    assign accept      = spike_valid & spike_ready;
    assign tick        = (state == SYN_ACTIVE) && (ps == PS_LAST);
    assign active      = (state == SYN_ACTIVE);

    // Small positive values shift to zero; force one LSB so decay always terminates.
    always_comb begin
        acc_shift = acc >>> DECAY_SHIFT;
        dec       = '0;
        if (tick) begin
            if (acc_shift == '0 && acc != '0) begin
                dec = acc[ACC_W-1] ? -ACC_W'(1) : ACC_W'(1);
            end else begin
                dec = acc_shift;
            end
        end
    end

    assign acc_ext = {{(SUM_W-ACC_W){acc[ACC_W-1]}}, acc};
    assign dec_ext = {{(SUM_W-ACC_W){dec[ACC_W-1]}}, dec};
    assign w_ext   = accept ? ({{(SUM_W-WIDTH){spike_weight[WIDTH-1]}}, spike_weight} <<< FRAC)
                            : '0;
    assign sum     = acc_ext - dec_ext + w_ext;

    qif_sat #(
        .IN_W  (SUM_W),
        .OUT_W (ACC_W)
    ) u_sat_acc (
        .din  (sum),
        .dout (acc_next),
        .clip (clip_acc)
    );

    assign acc_scaled = acc_next >>> FRAC;

    qif_sat #(
        .IN_W  (ACC_W),
        .OUT_W (WIDTH)
    ) u_sat_out (
        .din  (acc_scaled),
        .dout (i_next),
        .clip (clip_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q  <= 1'b0;
            acc      <= '0;
            I_syn    <= '0;
            state    <= SYN_IDLE;
            ps       <= '0;
            sat_flag <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (clr) begin
                acc      <= '0;
                I_syn    <= '0;
                state    <= SYN_IDLE;
                ps       <= '0;
                sat_flag <= 1'b0;
            end else begin
                acc      <= acc_next;
                I_syn    <= i_next;
                sat_flag <= sat_flag | clip_acc | clip_out;
                if (acc_next != '0) begin
                    state <= SYN_ACTIVE;
                    if (state == SYN_ACTIVE) begin
                        ps <= (ps == PS_LAST) ? '0 : ps + PS_W'(1);
                    end else begin
                        ps <= '0;
                    end
                end else begin
                    state <= SYN_IDLE;
                    ps    <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_qif_synapse.sv
// tb/tb_qif_synapse.sv - directed self-checking bench for qif_synapse
module tb_qif_synapse;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              spike_valid;
    logic signed [7:0] spike_weight;
    logic              spike_ready;
    logic signed [7:0] I_syn;
    logic              active;
    logic              sat_flag;

    int n_checks = 0;
    int n_fail   = 0;

    qif_synapse dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .clr          (clr),
        .spike_valid  (spike_valid),
        .spike_weight (spike_weight),
        .spike_ready  (spike_ready),
        .I_syn        (I_syn),
        .active       (active),
        .sat_flag     (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    task automatic spike(input int w);
        spike_valid  = 1'b1;
        spike_weight = 8'(w);
        step();
        spike_valid  = 1'b0;
    endtask

    int decay_seq [15] = '{14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0};

    initial begin
        rst_n        = 1'b0;
        clr          = 1'b0;
        spike_valid  = 1'b1;
        spike_weight = 8'sd50;

        // Reset held with a spike offered
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_isyn", int'(I_syn), 0);
            check("rst_active", int'(active), 0);
            check("rst_ready", int'(spike_ready), 0);
        end
        rst_n = 1'b1;
        step();
        spike_valid = 1'b0;
        check("rel_ready", int'(spike_ready), 1);
        check("rel_no_accept", int'(I_syn), 0);
        check("rel_active", int'(active), 0);

        // Single spike and first decay tick
        spike(40);
        check("single_isyn", int'(I_syn), 40);
        check("single_active", int'(active), 1);
        repeat (3) step();
        check("pre_tick_isyn", int'(I_syn), 40);
        step();
        check("tick_isyn", int'(I_syn), 35);
        do_clr();

        // Tick and spike on the same edge
        spike(40);
        repeat (3) step();
        spike(10);
        check("simul_isyn", int'(I_syn), 45);
        check("simul_acc", int'(dut.acc), 720);
        do_clr();

        // Positive saturation, clear, negative saturation
        spike_valid  = 1'b1;
        spike_weight = 8'sd127;
        step();
        check("satp1_isyn", int'(I_syn), 127);
        check("satp1_flag", int'(sat_flag), 0);
        step();
        check("satp2_isyn", int'(I_syn), 127);
        check("satp2_flag", int'(sat_flag), 1);
        step();
        check("satp3_isyn", int'(I_syn), 127);
        spike_valid = 1'b0;
        do_clr();
        check("clr_isyn", int'(I_syn), 0);
        check("clr_flag", int'(sat_flag), 0);
        check("clr_active", int'(active), 0);
        spike_valid  = 1'b1;
        spike_weight = -8'sd128;
        repeat (2) step();
        spike_valid = 1'b0;
        check("satn_isyn", int'(I_syn), -128);
        check("satn_flag", int'(sat_flag), 1);
        do_clr();

        // Decay from one LSB of current down to idle
        spike(1);
        check("decay_start", int'(dut.acc), 16);
        for (int k = 0; k < 15; k++) begin
            repeat (4) step();
            check($sformatf("decay_acc%0d", k), int'(dut.acc), decay_seq[k]);
            check($sformatf("decay_act%0d", k), int'(active), (k < 14) ? 1 : 0);
        end
        spike(1);
        repeat (3) step();
        check("restart_hold", int'(dut.acc), 16);
        step();
        check("restart_tick", int'(dut.acc), 14);
        do_clr();

        // Asynchronous reset between edges
        spike(40);
        repeat (4) step();
        check("mid_isyn", int'(I_syn), 35);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_isyn", int'(I_syn), 0);
        check("async_active", int'(active), 0);
        check("async_ready", int'(spike_ready), 0);
        step();
        rst_n = 1'b1;
        step();
        check("resume_ready", int'(spike_ready), 1);
        check("resume_active", int'(active), 0);
        spike(2);
        check("resume_isyn", int'(I_syn), 2);
        check("resume_act", int'(active), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
